// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: loads a PAT_W-bit pattern with repeat count and gap length, shifts it out MSB-first
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start_valid/ready load handshake; pattern, repeat_cnt, gap_len latched on a load
//   abort             synchronous cancel of a running transfer (no done pulse)
//   dout, dout_valid  serial bit stream and its qualifier
//   busy, done        transfer in progress; one-cycle pulse after the final bit of the final repetition
//
// Optional: define PATTERN_TX_PARITY_EN to append an even-parity bit after every repetition.
module serial_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(4'b1101)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(PAT_W);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
`ifdef PATTERN_TX_PARITY_EN
  localparam logic [1:0] PARITY = 2'd3;
`endif
  logic [1:0]       state;
  logic [PAT_W-1:0] pat_r;
  logic [BW-1:0]    bit_idx;
  logic [CNT_W-1:0] reps_left;
  logic [GAP_W-1:0] gap_len_r;
  logic [GAP_W-1:0] gap_cnt;
  logic             load;
  logic             rep_end;
  // abort wins over a simultaneous load request
  assign load = state == IDLE && start_valid && start_ready && !abort;
  // cycle in which the final bit of one repetition is on dout
`ifdef PATTERN_TX_PARITY_EN
  assign rep_end = state == PARITY;
`else
  assign rep_end = state == SEND && bit_idx == '0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pat_r       <= DEF_PATTERN;
      bit_idx     <= '0;
      reps_left   <= '0;
      gap_len_r   <= '0;
      gap_cnt     <= '0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state       <= IDLE;
        reps_left   <= '0;
        dout        <= 1'b0;
        dout_valid  <= 1'b0;
        busy        <= 1'b0;
        start_ready <= 1'b1;
      end else if (load) begin
        pat_r     <= pattern;
        reps_left <= repeat_cnt;
        gap_len_r <= gap_len;
        bit_idx   <= BW'(PAT_W - 1);
        if (repeat_cnt == '0) begin
          done <= 1'b1;
        end else begin
          state       <= SEND;
          dout        <= pattern[PAT_W-1];
          dout_valid  <= 1'b1;
          busy        <= 1'b1;
          start_ready <= 1'b0;
        end
      end else if (rep_end) begin
        bit_idx <= BW'(PAT_W - 1);
        if (reps_left > CNT_W'(1)) begin
          reps_left <= reps_left - 1'b1;
          if (gap_len_r != '0) begin
            state      <= GAP;
            gap_cnt    <= gap_len_r;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
          end else begin
            state      <= SEND;
            dout       <= pat_r[PAT_W-1];
            dout_valid <= 1'b1;
          end
        end else begin
          state       <= IDLE;
          reps_left   <= '0;
          dout        <= 1'b0;
          dout_valid  <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          start_ready <= 1'b1;
        end
      end else if (state == SEND) begin
`ifdef PATTERN_TX_PARITY_EN
        if (bit_idx == '0) begin
          state <= PARITY;
          dout  <= ^pat_r;
        end else
`endif
        begin
          bit_idx <= bit_idx - 1'b1;
          dout    <= pat_r[bit_idx - 1'b1];
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
        if (gap_cnt == GAP_W'(1)) begin
          state      <= SEND;
          dout       <= pat_r[PAT_W-1];
          dout_valid <= 1'b1;
        end
      end
    end
  end
endmodule
